// File: rtl/readout_word_serializer.sv
// Buffers 64-bit readout words in a small FIFO and re-emits each one
// as two 32-bit beats (upper half first) on a valid/ready stream.
module readout_word_serializer #(
    parameter int DEPTH = 8,
    parameter int DROPW = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [63:0]            in_data,
    input  logic                   in_valid,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic                   overflow,
    output logic [DROPW-1:0]       drop_count,
    output logic [31:0]            word_count,
    input  logic                   clear_stats
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        HI,
        LO
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [63:0]   head;
    logic          full;
    logic          hs;
    logic          pop;
    logic          wr_req;
    logic          push;
    logic          drop;

    assign head       = mem[rd_ptr_q];
    assign full       = (count_q == FULL);
    assign out_valid  = (count_q != '0);
    assign fill_level = count_q;

    assign hs     = out_valid & out_ready;
    assign pop    = hs & (state_q == LO);
    assign wr_req = in_valid & enable;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push   = wr_req & (~full | pop);
    assign drop   = wr_req & full & ~pop;

    always_comb begin
        state_d = state_q;
        if (hs) begin
            unique case (state_q)
                HI: state_d = LO;
                LO: state_d = HI;
                default: state_d = HI;
            endcase
        end
    end

    // Gated by out_valid so an empty FIFO presents zero, not stale data.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = (state_q == HI) ? head[63:32] : head[31:0];
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HI;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            word_count <= '0;
        end else if (clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            word_count <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROPW'(1);
                end
            end
            if (push) begin
                word_count <= word_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/readout_word_serializer.md
# readout_word_serializer

Downstream stage of the fast readout: accepts the 64-bit hit/debug words that the readout state machine writes (data plus write-enable, no back-pressure) and buffers them in a small FIFO. It re-emits each word as two 32-bit beats, upper half first, on a valid/ready stream toward the host-side readout FIFO. It tracks dropped words on overflow, holds a sticky overflow flag, and keeps an accepted-word counter for slow-control readback.

## Interface
Parameters:
- DEPTH, 8: FIFO entries of 64 bits; power of two, minimum 2.
- DROPW, 16: width of the saturating drop counter.

Ports:
- clock  input  1  single clock for the whole block.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  high: input words are accepted; low: input ignored, output keeps draining.
- in_data  input  64  data word from the readout state machine.
- in_valid  input  1  write strobe; one word per cycle; no back-pressure available.
- out_data  output  32  current output beat.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts the beat when high together with out_valid.
- fill_level  output  log2(DEPTH)+1  number of 64-bit entries currently stored (0..DEPTH).
- overflow  output  1  sticky; set when any word is dropped.
- drop_count  output  DROPW  number of dropped words; saturates at all-ones.
- word_count  output  32  number of accepted 64-bit words; wraps modulo 2^32.
- clear_stats  input  1  synchronous clear of overflow, drop_count and word_count.

## Operation
- Storage: register array of DEPTH x 64 bits, with write pointer, read pointer and count registers; pointers wrap modulo DEPTH.
- Push: occurs when in_valid and enable are high, and either count < DEPTH or a pop happens in the same cycle.
  - On push, the entry is written at the write pointer and word_count increments.
- Drop: occurs when in_valid and enable are high, count == DEPTH and no pop happens this cycle.
  - On drop, the word is discarded, overflow is set to 1 and drop_count increments unless it is already all-ones.
- in_valid with enable low: neither push nor drop; no counters change.
- Read FSM, two states:
  - HI: out_data = head[63:32].
  - LO: out_data = head[31:0].
  - out_valid = (count != 0) in both states.
  - HI -> LO on a handshake (out_valid & out_ready).
  - LO -> HI on a handshake; this is the pop, which advances the read pointer.
  - No handshake: the state holds.
- Count update: count += push − pop. A simultaneous push and pop leaves count unchanged.
- fill_level = count.
- clear_stats has priority over the increment and set terms in the same cycle: overflow, drop_count and word_count become 0. FIFO contents and FSM state are untouched.
- Reset (asynchronous assertion): state HI, pointers 0, count 0, out_valid 0, out_data 0, overflow 0, drop_count 0, word_count 0, fill_level 0.
  - Reset mid-word discards the pending LO beat and all stored entries.
  - Reset deassertion must be synchronized externally to clock.

## Timing
- out_data and out_valid are combinational from registered state only (head entry, count, FSM state); there is no path from in_* to out_*.
- Latency: a word pushed at edge N into an empty FIFO gives out_valid = 1 and the HI beat from edge N. The LO beat is presented at the earliest one cycle after the HI handshake.
- Sustained throughput: one beat per cycle, i.e. one 64-bit word per two cycles. Input faster than that fills the FIFO.
- Stability rule: while out_valid = 1 and out_ready = 0, out_data and out_valid are held constant.
- Counters, overflow and fill_level update on the same edge as the push, drop or pop that causes them.

## Test plan
- Single word: push 0x0123456789ABCDEF with out_ready = 1 → beats 0x01234567 then 0x89ABCDEF on consecutive cycles; word_count = 1; fill_level returns to 0; out_valid then drops.
- Overflow: out_ready = 0, push 10 consecutive words 1..10 (DEPTH = 8) → fill_level = 8, drop_count = 2, overflow = 1. Then set out_ready = 1 → 16 beats carrying words 1..8 in order; words 9 and 10 never appear.
- Push at full with pop: FIFO full, FSM in LO, out_ready = 1, and in_valid in the same cycle → word is accepted, drop_count unchanged, fill_level stays 8.
- Back-pressure: toggle out_ready pseudo-randomly over 100 words → output stream equals the input sequence split high/low; out_data never changes while stalled.
- enable/clear: with enable = 0, 5 pushes → no change. Then clear_stats coincident with a drop → overflow = 0, drop_count = 0. Force 65 537 drops → drop_count = 0xFFFF.
- Reset mid-operation: assert reset_n = 0 while FSM in LO with 3 entries stored → all outputs are 0 immediately, without waiting for a clock edge. After release, a fresh word emits its HI beat first.
